// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_XOR  = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MUL  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } op_e;

    // Number of defined opcodes; anything at or above this is illegal.
    localparam logic [3:0] OP_COUNT = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        HOLD     = 2'd2
    } state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op >= OP_COUNT;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH
// bits of the unsigned product. done_o flags the cycle whose edge completes
// the product; product_o is valid during that cycle.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] partial, sum_d;
    logic [CW-1:0]    cnt_q;

    // Partial product for the current multiplier bit; the last step's sum is the result.
    always_comb begin
        partial   = mplier_q[0] ? mcand_q : '0;
        sum_d     = acc_q + partial;
        done_o    = (cnt_q == CW'(1));
        product_o = sum_d;
    end

    // Down-counter sequences WIDTH steps; operands shift one bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= sum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
//   state    | meaning
//   IDLE     | no result pending, ready for a request
//   MUL_BUSY | iterative multiply in progress, requests blocked
//   HOLD     | result and flags presented until the consumer takes them
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, neg_q;
    logic             carry_q, carry_d, ovf_q, ovf_d, illegal_q, illegal_d;
    logic             accept, mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [SHW-1:0]   shamt;

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign c         = c_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = illegal_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle datapath; carry on SUB is the borrow (a < b unsigned).
    always_comb begin
        add_ext   = {1'b0, a} + {1'b0, b};
        sub_ext   = {1'b0, a} - {1'b0, b};
        shamt     = b[SHW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (control)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_ext[WIDTH-1:0];
                alu_carry = sub_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // Next state and result capture; a HOLD transfer may overlap a new accept.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (control == OP_MUL) begin
                        state_d   = MUL_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_d   = HOLD;
                        c_d       = alu_res;
                        carry_d   = alu_carry;
                        ovf_d     = alu_ovf;
                        illegal_d = op_is_illegal(control);
                    end
                end else if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d   = HOLD;
                    c_d       = mul_product;
                    carry_d   = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result and flag registers; zero/negative follow the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            zero_q    <= (c_d == '0);
            neg_q     <= c_d[WIDTH-1];
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance for most vectors and an
// 8-bit instance for the narrow shift/compare cases.
module tb_alu_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  control;
    logic [31:0] a, b, c;
    logic        zero, negative, carry, overflow, illegal;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]  control8;
    logic [7:0]  a8, b8, c8;
    logic        zero8, negative8, carry8, overflow8, illegal8;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .control(control),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .illegal(illegal)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .control(control8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .c(c8),
        .zero(zero8), .negative(negative8), .carry(carry8),
        .overflow(overflow8), .illegal(illegal8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, negative, carry, overflow, illegal}
    typedef struct {
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] cv;
        logic [4:0]  fl;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cycles;
        int leak;
        int seen;
        logic [31:0] va, vb;

        tbl[0]  = '{4'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 5'b00000};
        tbl[1]  = '{4'd3,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 5'b01000};
        tbl[2]  = '{4'd4,  32'h0000_0001, 32'hFFFF_FF24, 32'h0000_0010, 5'b00000};
        tbl[3]  = '{4'd5,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 5'b00000};
        tbl[4]  = '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5'b01000};
        tbl[5]  = '{4'd10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000};
        tbl[6]  = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 5'b10000};
        tbl[7]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010};
        tbl[8]  = '{4'd6,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 5'b01100};
        tbl[9]  = '{4'd11, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 5'b10001};
        tbl[10] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'b10001};
        tbl[11] = '{4'd1,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 5'b00000};

        in_valid = 0; out_ready = 0; control = 0; a = 0; b = 0;
        in_valid8 = 0; out_ready8 = 0; control8 = 0; a8 = 0; b8 = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_c", c, 0);
        check("rst_flags", {zero, negative, carry, overflow, illegal}, 5'b10000);
        check("rst8_c_flags", {c8, zero8, negative8, carry8, overflow8, illegal8, out_valid8, in_ready8}, {8'h00, 7'b1000001});
        rst_n = 1;

        // ADD wrap to zero
        in_valid = 1; out_ready = 1; control = 4'd2; a = 32'hFFFF_FFFF; b = 32'h1;
        @(negedge clk);
        check("add_wrap_valid", out_valid, 1);
        check("add_wrap_c", c, 32'h0);
        check("add_wrap_flags", {zero, negative, carry, overflow, illegal}, 5'b10100);

        // SUB signed overflow
        control = 4'd6; a = 32'h8000_0000; b = 32'h1;
        @(negedge clk);
        check("sub_ovf_c", c, 32'h7FFF_FFFF);
        check("sub_ovf_flags", {zero, negative, carry, overflow, illegal}, 5'b00010);

        // directed single-cycle table, back to back
        for (int i = 0; i < 12; i++) begin
            control = tbl[i].op; a = tbl[i].av; b = tbl[i].bv;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), out_valid, 1);
            check($sformatf("tbl%0d_c", i), c, tbl[i].cv);
            check($sformatf("tbl%0d_flags", i), {zero, negative, carry, overflow, illegal}, tbl[i].fl);
        end

        // MUL: accepted out of HOLD, then inputs must be ignored while busy
        control = 4'd8; a = 32'h0001_0003; b = 32'h0000_0005;
        @(posedge clk);
        #1;
        out_ready = 0; control = 4'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        cycles = 0; leak = 0;
        @(negedge clk);
        while (!out_valid && cycles < 100) begin
            if (in_ready) leak++;
            cycles++;
            @(negedge clk);
        end
        check("mul_latency", cycles, 32);
        check("mul_ready_leak", leak, 0);
        check("mul_c", c, 32'h0005_000F);
        check("mul_flags", {zero, negative, carry, overflow, illegal}, 5'b00000);

        // consumer stalls: result must hold, no accept
        control = 4'd1; a = 32'h0; b = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_c", i), c, 32'h0005_000F);
            check($sformatf("stall%0d_ctl", i), {out_valid, in_ready}, 2'b10);
        end

        // eight back-to-back OR requests, one result per cycle
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            va = i * 32'h0101_0101;
            vb = 32'h8000_0000 >> i;
            a = va; b = vb;
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i), out_valid, 1);
            check($sformatf("b2b%0d_c", i), c, va | vb);
        end
        in_valid = 0;
        @(negedge clk);
        check("b2b_drain", {out_valid, in_ready}, 2'b01);

        // reset mid-multiply, then an illegal op
        in_valid = 1; control = 4'd8; a = 32'h0001_0003; b = 32'h0000_0005;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("midrst_ctl", {out_valid, in_ready}, 2'b01);
        check("midrst_c", c, 32'h0);
        check("midrst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; out_ready = 1; control = 4'd13; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        check("ill_valid", out_valid, 1);
        check("ill_c", c, 32'h0);
        check("ill_flags", {zero, negative, carry, overflow, illegal}, 5'b10001);
        in_valid = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_mul", seen, 0);

        // 8-bit instance: SRA with upper shift bits ignored, then SLT
        in_valid8 = 1; out_ready8 = 1; control8 = 4'd7; a8 = 8'h90; b8 = 8'hF3;
        @(negedge clk);
        check("w8_sra_c", c8, 8'hF2);
        check("w8_sra_flags", {out_valid8, zero8, negative8, carry8, overflow8, illegal8}, 6'b101000);
        control8 = 4'd9; a8 = 8'hFF; b8 = 8'h01;
        @(negedge clk);
        check("w8_slt_c", c8, 8'h01);
        check("w8_slt_flags", {out_valid8, zero8, negative8}, 3'b100);
        in_valid8 = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
